// File: rtl/histogram_frame_sequencer.sv
// -----------------------------------------------------------------------------
// histogram_frame_sequencer
//
// Per-frame controller for the gray-level histogram datapath. It lets the
// histogram accumulator run for exactly one whole frame. It then scans the
// 256-bin histogram RAM and, during that scan, builds the cumulative histogram,
// the peak bin count and the percentile threshold bin. Finally it clears the
// histogram RAM so it is ready for the next frame.
//
// Optional feature macro: HISTSEQ_THRESH_SMOOTH_EN
//   defined   : oThresh is the rounded mean of the previous oThresh and the new
//               threshold bin. The first result after reset is loaded directly.
//   undefined : oThresh takes the new threshold bin directly.
//
// Ports
//   iClk            clock
//   iRst            synchronous reset, active-high
//   iFval           frame valid from the camera path
//   iThreshPercent  threshold fraction in 1/256 units, latched when SCAN starts
//   oAccumEn        histogram accumulator may increment bins
//   oHistRdAddr     histogram RAM read address (1-cycle read latency)
//   iHistRdData     histogram RAM read data
//   oHistWrEn       histogram RAM write enable (clearing only)
//   oHistWrAddr     histogram RAM write address
//   oHistWrData     histogram RAM write data (always 0)
//   oCumWrEn        cumulative RAM write enable
//   oCumWrAddr      cumulative RAM write address
//   oCumWrData      cumulative value (saturating)
//   oMaxValue       peak bin count of the last completed frame
//   oThresh         threshold bin of the last completed frame
//   oBusy           high while scanning or clearing
//   oDone           one-cycle pulse when oMaxValue/oThresh update
// -----------------------------------------------------------------------------
module histogram_frame_sequencer #(
    parameter int BIN_W        = 20,
    parameter int TOTAL_PIXELS = 384000
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iFval,
    input  logic [7:0]       iThreshPercent,
    output logic             oAccumEn,
    output logic [7:0]       oHistRdAddr,
    input  logic [BIN_W-1:0] iHistRdData,
    output logic             oHistWrEn,
    output logic [7:0]       oHistWrAddr,
    output logic [BIN_W-1:0] oHistWrData,
    output logic             oCumWrEn,
    output logic [7:0]       oCumWrAddr,
    output logic [BIN_W-1:0] oCumWrData,
    output logic [BIN_W-1:0] oMaxValue,
    output logic [7:0]       oThresh,
    output logic             oBusy,
    output logic             oDone
);

    // Width used to compare the running sum against the 28-bit target.
    localparam int CMP_W = (BIN_W > 28) ? BIN_W : 28;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCUM,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [8:0]       addr_reg, addr_next;
    logic             after_scan_reg, after_scan_next;
    logic             fval_reg;
    logic [27:0]      target_reg;
    logic [BIN_W-1:0] sum_reg;
    logic [BIN_W-1:0] max_reg;
    logic             found_reg;
    logic [7:0]       thr_reg;
    logic [BIN_W-1:0] max_value_reg;
    logic [7:0]       thresh_reg;
`ifdef HISTSEQ_THRESH_SMOOTH_EN
    logic             smooth_valid_reg;
    logic [8:0]       thresh_sum;
`endif

    logic             fval_rise;
    logic             fval_fall;
    logic             scan_wr;
    logic [7:0]       scan_wr_addr;
    logic [BIN_W:0]   sum_wide;
    logic [BIN_W-1:0] sum_new;
    logic [CMP_W-1:0] sum_cmp;
    logic [CMP_W-1:0] target_cmp;
    logic             target_hit;
    logic [27:0]      target_full;

    assign fval_rise = iFval & ~fval_reg;
    assign fval_fall = ~iFval & fval_reg;

    // SCAN runs addr_reg 0..256: the read for bin k is issued at addr_reg=k
    // and its data is consumed (and the cumulative write made) at addr_reg=k+1.
    assign scan_wr      = (state_reg == ST_SCAN) && (addr_reg != 9'd0);
    assign scan_wr_addr = addr_reg[7:0] - 8'd1;

    assign sum_wide = {1'b0, sum_reg} + {1'b0, iHistRdData};
    assign sum_new  = sum_wide[BIN_W] ? {BIN_W{1'b1}} : sum_wide[BIN_W-1:0];

    assign sum_cmp    = CMP_W'(sum_new);
    assign target_cmp = CMP_W'(target_reg);
    assign target_hit = (sum_cmp >= target_cmp);

    assign target_full = 28'(TOTAL_PIXELS) * 28'(iThreshPercent);

`ifdef HISTSEQ_THRESH_SMOOTH_EN
    assign thresh_sum = {1'b0, thresh_reg} + {1'b0, thr_reg} + 9'd1;
`endif

    // Next-state logic.
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        after_scan_next = after_scan_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (addr_reg == 9'd255) begin
                    addr_next       = 9'd0;
                    after_scan_next = 1'b0;
                    // The clear that follows reset has no results to publish.
                    state_next      = after_scan_reg ? ST_DONE : ST_IDLE;
                end else begin
                    addr_next = addr_reg + 9'd1;
                end
            end
            ST_IDLE: begin
                // A frame that is already running when IDLE is entered shows no
                // rising edge here, so partial frames are skipped.
                if (fval_rise) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (fval_fall) begin
                    state_next = ST_SCAN;
                    addr_next  = 9'd0;
                end
            end
            ST_SCAN: begin
                if (addr_reg == 9'd256) begin
                    state_next      = ST_CLEAR;
                    addr_next       = 9'd0;
                    after_scan_next = 1'b1;
                end else begin
                    addr_next = addr_reg + 9'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_CLEAR;
                addr_next  = 9'd0;
            end
        endcase
    end

    // State, scan accumulators and published results.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg      <= ST_CLEAR;
            addr_reg       <= 9'd0;
            after_scan_reg <= 1'b0;
            fval_reg       <= 1'b0;
            target_reg     <= 28'd0;
            sum_reg        <= '0;
            max_reg        <= '0;
            found_reg      <= 1'b0;
            thr_reg        <= 8'd0;
            max_value_reg  <= '0;
            thresh_reg     <= 8'd0;
`ifdef HISTSEQ_THRESH_SMOOTH_EN
            smooth_valid_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            after_scan_reg <= after_scan_next;
            fval_reg       <= iFval;

            // Entering SCAN: latch the percentile target and restart the scan.
            if ((state_reg == ST_ACCUM) && fval_fall) begin
                target_reg <= target_full >> 8;
                sum_reg    <= '0;
                max_reg    <= '0;
                found_reg  <= 1'b0;
                thr_reg    <= 8'd255;
            end

            if (scan_wr) begin
                sum_reg <= sum_new;
                if (iHistRdData > max_reg) begin
                    max_reg <= iHistRdData;
                end
                if (!found_reg && target_hit) begin
                    found_reg <= 1'b1;
                    thr_reg   <= scan_wr_addr;
                end
            end

            if (state_reg == ST_DONE) begin
                max_value_reg <= max_reg;
`ifdef HISTSEQ_THRESH_SMOOTH_EN
                smooth_valid_reg <= 1'b1;
                if (smooth_valid_reg) begin
                    thresh_reg <= thresh_sum[8:1];
                end else begin
                    thresh_reg <= thr_reg;
                end
`else
                thresh_reg <= thr_reg;
`endif
            end
        end
    end

    // Outputs.
    assign oAccumEn    = (state_reg == ST_ACCUM) && fval_reg && iFval;
    assign oHistRdAddr = (state_reg == ST_SCAN) ? addr_reg[7:0] : 8'd0;
    // No RAM writes while reset is held; the clear sweep starts on release.
    assign oHistWrEn   = (state_reg == ST_CLEAR) && !iRst;
    assign oHistWrAddr = (state_reg == ST_CLEAR) ? addr_reg[7:0] : 8'd0;
    assign oHistWrData = '0;
    assign oCumWrEn    = scan_wr;
    assign oCumWrAddr  = scan_wr ? scan_wr_addr : 8'd0;
    assign oCumWrData  = scan_wr ? sum_new : '0;
    assign oMaxValue   = max_value_reg;
    assign oThresh     = thresh_reg;
    assign oBusy       = (state_reg == ST_SCAN) || (state_reg == ST_CLEAR);
    assign oDone       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_histogram_frame_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for histogram_frame_sequencer. A behavioural histogram RAM is
// preloaded with a bin pattern and then a frame is played. The cumulative
// writes, clear sweep and published results are compared with a reference
// computed directly from the bin pattern (prefix sums, maximum, first bin
// reaching the target).
// -----------------------------------------------------------------------------
module tb_histogram_frame_sequencer;

    localparam int BIN_W = 20;
    localparam int TOTAL = 384000;
    localparam logic [BIN_W-1:0] SAT = {BIN_W{1'b1}};

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iFval;
    logic [7:0]       iThreshPercent;
    logic             oAccumEn;
    logic [7:0]       oHistRdAddr;
    logic [BIN_W-1:0] iHistRdData;
    logic             oHistWrEn;
    logic [7:0]       oHistWrAddr;
    logic [BIN_W-1:0] oHistWrData;
    logic             oCumWrEn;
    logic [7:0]       oCumWrAddr;
    logic [BIN_W-1:0] oCumWrData;
    logic [BIN_W-1:0] oMaxValue;
    logic [7:0]       oThresh;
    logic             oBusy;
    logic             oDone;

    histogram_frame_sequencer #(.BIN_W(BIN_W), .TOTAL_PIXELS(TOTAL)) dut (
        .iClk(iClk), .iRst(iRst), .iFval(iFval), .iThreshPercent(iThreshPercent),
        .oAccumEn(oAccumEn), .oHistRdAddr(oHistRdAddr), .iHistRdData(iHistRdData),
        .oHistWrEn(oHistWrEn), .oHistWrAddr(oHistWrAddr), .oHistWrData(oHistWrData),
        .oCumWrEn(oCumWrEn), .oCumWrAddr(oCumWrAddr), .oCumWrData(oCumWrData),
        .oMaxValue(oMaxValue), .oThresh(oThresh), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    // Histogram RAM with registered read.
    logic [BIN_W-1:0] hist_mem [256];
    always @(posedge iClk) begin
        iHistRdData <= hist_mem[oHistRdAddr];
        if (oHistWrEn === 1'b1) hist_mem[oHistWrAddr] = '0;
    end

    int errors = 0;
    int checks = 0;
    int frame_no = 0;

    // Monitor statistics, sampled on the falling edge.
    int cum_cnt, clr_cnt, done_cnt, order_bad, overlap_bad;
    logic [BIN_W-1:0] cum_got [256];

    always @(negedge iClk) begin
        if (oCumWrEn === 1'b1) begin
            if (oCumWrAddr != cum_cnt[7:0]) order_bad++;
            cum_got[oCumWrAddr] = oCumWrData;
            cum_cnt++;
        end
        if (oHistWrEn === 1'b1) begin
            if (oHistWrAddr != clr_cnt[7:0] || oHistWrData != '0) order_bad++;
            clr_cnt++;
        end
        if (oDone === 1'b1) done_cnt++;
        if (oCumWrEn === 1'b1 && oHistWrEn === 1'b1) overlap_bad++;
        if (oAccumEn === 1'b1 && oBusy === 1'b1) overlap_bad++;
    end

    // Reference data.
    logic [BIN_W-1:0] img [256];
    logic [BIN_W-1:0] exp_cum [256];
    logic [BIN_W-1:0] exp_max;
    logic [7:0]       exp_thr;
    logic [BIN_W-1:0] last_max;
    logic [7:0]       last_out;
    bit               smooth_have;

    typedef struct {
        int               pat;
        logic [7:0]       pct;
        logic [BIN_W-1:0] emax;
        logic [7:0]       ethr;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s (frame %0d): got %0d, required %0d", name, frame_no, act, req);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic clear_stats();
        cum_cnt = 0; clr_cnt = 0; done_cnt = 0; order_bad = 0; overlap_bad = 0;
        for (int k = 0; k < 256; k++) cum_got[k] = '0;
    endtask

    // 0: bins 10/200; 1: flat 1500; 2: saturating head; 3: random.
    task automatic load_pattern(input int pat);
        logic [BIN_W-1:0] v;
        for (int k = 0; k < 256; k++) begin
            case (pat)
                0: v = (k == 10) ? BIN_W'(1000) : ((k == 200) ? BIN_W'(3000) : '0);
                1: v = BIN_W'(1500);
                2: v = (k < 4) ? SAT : '0;
                default: v = ($urandom_range(0, 31) == 0) ? BIN_W'($urandom_range(0, 1048575))
                                                          : BIN_W'($urandom_range(0, 3000));
            endcase
            img[k] = v;
            hist_mem[k] = v;
        end
    endtask

    task automatic model(input logic [7:0] pct);
        longint target, run;
        bit found;
        target = (longint'(TOTAL) * longint'(pct)) / 256;
        run = 0; found = 0; exp_max = '0; exp_thr = 8'd255;
        for (int k = 0; k < 256; k++) begin
            run += longint'(img[k]);
            if (run > longint'(SAT)) run = longint'(SAT);
            exp_cum[k] = BIN_W'(run);
            if (img[k] > exp_max) exp_max = img[k];
            if (!found && run >= target) begin
                found = 1;
                exp_thr = 8'(k);
            end
        end
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        iFval = 1'b0;
        tick();
        tick();
        @(negedge iClk);
        check("rst_hist_wr_en", oHistWrEn, 0);
        check("rst_cum_wr_en", oCumWrEn, 0);
        check("rst_accum_en", oAccumEn, 0);
        check("rst_done", oDone, 0);
        check("rst_busy", oBusy, 1);
        tick();
        clear_stats();
        iRst = 1'b0;
        for (int n = 0; n < 400 && oBusy !== 1'b0; n++) tick();
        @(negedge iClk);
        check("rst_clear_writes", clr_cnt, 256);
        check("rst_clear_order", order_bad, 0);
        check("rst_no_done", done_cnt, 0);
        check("rst_busy_low", oBusy, 0);
        check("rst_max_value", oMaxValue, 0);
        check("rst_thresh", oThresh, 0);
        last_max = '0;
        last_out = 8'd0;
        smooth_have = 0;
        $display("reset: clear writes=%0d", clr_cnt);
    endtask

    task automatic start_frame(input logic [7:0] pct, input int len);
        int bad;
        for (int n = 0; n < 1000 && oBusy !== 1'b0; n++) tick();
        frame_no++;
        iThreshPercent = pct;
        clear_stats();
        iFval = 1'b1;
        tick();
        bad = 0;
        for (int c = 0; c < len; c++) begin
            @(negedge iClk);
            if (oAccumEn !== 1'b1) bad++;
            tick();
        end
        check("accum_high", bad, 0);
        // Results of the previous frame stay put while this frame runs.
        check("stable_max", oMaxValue, last_max);
        check("stable_thresh", oThresh, last_out);
        iFval = 1'b0;
        #1;
        check("accum_drop", oAccumEn, 0);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 800 && done_cnt == 0; n++) tick();
        tick();
    endtask

    task automatic check_frame(input logic [BIN_W-1:0] emax, input logic [7:0] ethr);
        int bad, dirty;
        logic [7:0] eout;
        bad = 0; dirty = 0;
        for (int k = 0; k < 256; k++) begin
            if (cum_got[k] !== exp_cum[k]) bad++;
            if (hist_mem[k] != '0) dirty++;
        end
`ifdef HISTSEQ_THRESH_SMOOTH_EN
        eout = smooth_have ? 8'((9'(last_out) + 9'(ethr) + 9'd1) >> 1) : ethr;
`else
        eout = ethr;
`endif
        check("cum_writes", cum_cnt, 256);
        check("cum_value_mismatches", bad, 0);
        check("clear_writes", clr_cnt, 256);
        check("ram_not_cleared", dirty, 0);
        check("order_faults", order_bad, 0);
        check("overlap_faults", overlap_bad, 0);
        check("done_pulses", done_cnt, 1);
        check("max_value", oMaxValue, emax);
        check("thresh", oThresh, eout);
        $display("frame %0d: max=%0d thresh=%0d (required %0d/%0d) cum_writes=%0d",
                 frame_no, oMaxValue, oThresh, emax, eout, cum_cnt);
        last_max = emax;
        last_out = eout;
        smooth_have = 1;
    endtask

    task automatic run_frame(input int pat, input logic [7:0] pct, input int len);
        load_pattern(pat);
        model(pct);
        start_frame(pct, len);
        wait_done();
    endtask

    initial begin
        iRst = 1'b1;
        iFval = 1'b0;
        iThreshPercent = 8'd0;
        for (int k = 0; k < 256; k++) hist_mem[k] = '0;
        clear_stats();

        vecs[0] = '{pat: 0, pct: 8'd128, emax: BIN_W'(3000), ethr: 8'd255};
        vecs[1] = '{pat: 1, pct: 8'd128, emax: BIN_W'(1500), ethr: 8'd127};
        vecs[2] = '{pat: 2, pct: 8'd128, emax: SAT,          ethr: 8'd0};
        vecs[3] = '{pat: 0, pct: 8'd0,   emax: BIN_W'(3000), ethr: 8'd0};
        vecs[4] = '{pat: 1, pct: 8'd255, emax: BIN_W'(1500), ethr: 8'd254};
        vecs[5] = '{pat: 1, pct: 8'd1,   emax: BIN_W'(1500), ethr: 8'd0};

        do_reset();

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].pat, vecs[i].pct, 8 + i);
            check_frame(vecs[i].emax, vecs[i].ethr);
        end

        // Frame start during CLEAR is dropped; the next frame runs normally.
        load_pattern(0);
        model(8'd128);
        start_frame(8'd128, 12);
        for (int n = 0; n < 800 && clr_cnt < 200; n++) tick();
        iFval = 1'b1;
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge iClk);
                if (oAccumEn !== 1'b0) bad++;
                tick();
            end
            check("dropped_accum", bad, 0);
        end
        iFval = 1'b0;
        tick();
        check_frame(BIN_W'(3000), 8'd255);
        run_frame(1, 8'd128, 20);
        check_frame(BIN_W'(1500), 8'd127);

        // Randomized frames against the reference.
        for (int r = 0; r < 5; r++) begin
            logic [7:0] pct;
            pct = 8'($urandom_range(0, 255));
            run_frame(3, pct, int'($urandom_range(2, 30)));
            check_frame(exp_max, exp_thr);
        end

        // Reset in the middle of a scan.
        load_pattern(1);
        model(8'd128);
        start_frame(8'd128, 6);
        for (int n = 0; n < 400 && cum_cnt < 50; n++) tick();
        check("mid_scan_reached", (cum_cnt >= 50) ? 1 : 0, 1);
        do_reset();

`ifdef HISTSEQ_THRESH_SMOOTH_EN
        run_frame(1, 8'd101, 10);
        check_frame(BIN_W'(1500), 8'd100);
        check("smooth_first", oThresh, 100);
        run_frame(1, 8'd52, 10);
        check_frame(BIN_W'(1500), 8'd51);
        check("smooth_second", oThresh, 76);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
